vga_box_compositor: RTL
=======================

// Module: vga_box_compositor
// PURPOSE
//  Parametrised N-box overlay stage between the VGA timing generator and the VGA pins.
//  Latches per-box position, size, colour and mode once per frame, then composites the boxes over the background pixel stream.
//  Also delays hSync/vSync to stay aligned with the pixel pipeline.
//  Generalises the fixed player/target boxes: any count, per-box size, clamped edges, outline and blink modes.
// PARAMETERS
//  N_BOXES      2    number of overlay boxes; index 0 has the highest priority
//  WIDTH        640  active pixels per line
//  HEIGHT       480  active lines per frame
//  HALF_W       6    width of each box half-size field (max half-size 63)
//  BORDER_W     3    outline thickness in pixels (mode OUTLINE)
//  BLINK_SHIFT  4    blink period is 2^(BLINK_SHIFT+1) frames, 50% duty
//  SYNC_IDLE    1'b1 reset/idle level of hSync and vSync outputs
// PORTS
//  clk_25mHz   in   1           pixel clock; the only clock
//  reset       in   1           asynchronous, active-low reset
//  frame_end   in   1           screenEnd from the timing generator; level, sampled on clk
//  active_in   in   1           timing-generator active flag
//  hsync_in    in   1           timing-generator hSync
//  vsync_in    in   1           timing-generator vSync
//  x           in   10          current pixel x
//  y           in   9           current pixel y
//  bg_color    in   12          background colour for the same pixel, already aligned with x/y
//  box_cx      in   N_BOXES*10  centre x, box i at [10i+9:10i]
//  box_cy      in   N_BOXES*9   centre y
//  box_half    in   N_BOXES*HALF_W  half-size
//  box_color   in   N_BOXES*12  RGB444 colour
//  box_mode    in   N_BOXES*2   00 SOLID, 01 OUTLINE, 10 BLINK, 11 HIDDEN
//  hSync       out  1           hsync_in delayed 2 cycles
//  vSync       out  1           vsync_in delayed 2 cycles
//  VGA_R       out  4           composited red
//  VGA_G       out  4           composited green
//  VGA_B       out  4           composited blue
//  hit_mask    out  N_BOXES     per-box hit for the displayed pixel (after mode filtering), aligned with VGA_*
// BEHAVIOUR
//  Reset (reset==0, async): shadow regs, frame_cnt, pipeline and hit_mask clear to 0.
//   VGA_R/G/B=0; hSync=vSync=SYNC_IDLE; all boxes HIDDEN until the first frame_end rise.
//  frame_end: rising edge detected on clk (1-cycle delayed copy); frame_end is never used as a clock.
//   On the edge cycle: every box_* input is captured into shadow regs and frame_cnt (8b) increments, wrapping 255->0.
//   Mid-frame input changes have no visible effect until the next edge.
//  Bounds are computed from the shadow regs in the cycle after capture, with 11-bit intermediates:
//   L = (cx<half) ? 0 : cx-half;  R = min(cx+half, WIDTH-1);  T/B likewise against HEIGHT-1.
//   No wrap-around; a box partly off-screen is clipped.
//  inside_i = L<=x<=R && T<=y<=B (inclusive, so the box is 2*half+1 square).
//  Mode filtering:
//   SOLID = inside.
//   OUTLINE = inside && (x<L+BORDER_W || x>R-BORDER_W || y<T+BORDER_W || y>B-BORDER_W).
//   BLINK = inside && frame_cnt[BLINK_SHIFT].
//   HIDDEN = 0.
//   half==0 gives a single pixel.
//  Pipeline: S1 registers hit vector, bg_color, active, syncs. S2 selects the lowest-index hit colour,
//   else bg; outputs 0 when active is low; registers VGA_*, hit_mask, syncs. Latency exactly 2 clk, fully pipelined.
//  Simultaneous frame_end rise and pixel: bounds for the new frame are first used 2 cycles after the edge (blanking period).
//  Reset mid-frame: outputs return to reset values immediately; normal output resumes after the next frame_end rise.
// STRUCTURE
//  Package vga_box_pkg: MODE_SOLID/OUTLINE/BLINK/HIDDEN encodings, X_W=10, Y_W=9, COLOR_W=12, FRAME_CNT_W=8.
//  Sub-module vga_box_hit (one per box, generate loop): shadow regs, bound computation, mode-filtered hit.
//  Top level: edge detect, frame_cnt, priority mux, S1/S2 pipeline.
// TESTING
//  Reset held low, toggle inputs -> VGA_*=0, hSync=vSync=1, hit_mask=0.
//  Box0 cx=100 cy=100 half=25 SOLID red 12'hF00, edge -> pixel (75,75) and (125,125) red, (74,75) = bg, 2-cycle latency.
//  Box0 cx=10 half=25 -> L clamped to 0; pixel (0,cy) hit, (630,cy) not hit (no wrap).
//  Boxes 0 and 1 overlap, both SOLID -> overlap pixel shows box0 colour, hit_mask=2'b11.
//  Box0 OUTLINE half=10 BORDER_W=3 -> centre pixel is bg, pixel L+2 coloured, pixel L+3 is bg.
//  Box0 BLINK, BLINK_SHIFT=4 -> visible frames 16-31, hidden 0-15 and 32-47; mid-frame cx change applies next frame only.

Source files
------------

// File: rtl/vga_box_pkg.sv
// Shared encodings and widths for the VGA box compositor.
// Boxes are latched once per frame and composited over the background stream.
package vga_box_pkg;

  localparam int unsigned X_W         = 10;
  localparam int unsigned Y_W         = 9;
  localparam int unsigned COLOR_W     = 12;
  localparam int unsigned FRAME_CNT_W = 8;

  localparam logic [1:0] MODE_SOLID   = 2'b00;
  localparam logic [1:0] MODE_OUTLINE = 2'b01;
  localparam logic [1:0] MODE_BLINK   = 2'b10;
  localparam logic [1:0] MODE_HIDDEN  = 2'b11;

  function automatic logic [10:0] clamp_hi(input logic [10:0] v, input logic [10:0] lim);
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/vga_box_hit.sv
// One overlay box: per-frame shadow registers, clipped bounds and mode-filtered hit test.
// The hit output is combinational on the current pixel; the top registers it.
module vga_box_hit
  import vga_box_pkg::*;
#(
  parameter int unsigned WIDTH       = 640,
  parameter int unsigned HEIGHT      = 480,
  parameter int unsigned HALF_W      = 6,
  parameter int unsigned BORDER_W    = 3
) (
  input  logic               clk_25mHz,
  input  logic               reset,
  input  logic               i_capture,
  input  logic [X_W-1:0]     i_cx,
  input  logic [Y_W-1:0]     i_cy,
  input  logic [HALF_W-1:0]  i_half,
  input  logic [COLOR_W-1:0] i_color,
  input  logic [1:0]         i_mode,
  input  logic [X_W-1:0]     i_x,
  input  logic [Y_W-1:0]     i_y,
  input  logic               i_blink_on,
  output logic               o_hit,
  output logic [COLOR_W-1:0] o_color
);

  logic               r_valid;
  logic [X_W-1:0]     r_cx;
  logic [Y_W-1:0]     r_cy;
  logic [HALF_W-1:0]  r_half;
  logic [COLOR_W-1:0] r_color;
  logic [1:0]         r_mode;

  logic               r_bnd_valid;
  logic [10:0]        r_l, r_r, r_t, r_b;
  logic [1:0]         r_bnd_mode;
  logic [COLOR_W-1:0] r_bnd_color;

  logic [10:0] w_cx, w_cy, w_half, w_x, w_y;
  logic [10:0] w_l, w_r, w_t, w_b;
  logic        w_inside, w_border;

  assign w_cx   = 11'(r_cx);
  assign w_cy   = 11'(r_cy);
  assign w_half = 11'(r_half);
  assign w_x    = 11'(i_x);
  assign w_y    = 11'(i_y);

  assign w_l = (w_cx < w_half) ? 11'd0 : w_cx - w_half;
  assign w_r = clamp_hi(w_cx + w_half, 11'(WIDTH - 1));
  assign w_t = (w_cy < w_half) ? 11'd0 : w_cy - w_half;
  assign w_b = clamp_hi(w_cy + w_half, 11'(HEIGHT - 1));

  // Shadow regs start invalid so every box stays hidden until the first capture.
  always_ff @(posedge clk_25mHz or negedge reset) begin
    if (!reset) begin
      r_valid     <= 1'b0;
      r_cx        <= '0;
      r_cy        <= '0;
      r_half      <= '0;
      r_color     <= '0;
      r_mode      <= '0;
      r_bnd_valid <= 1'b0;
      r_l         <= '0;
      r_r         <= '0;
      r_t         <= '0;
      r_b         <= '0;
      r_bnd_mode  <= '0;
      r_bnd_color <= '0;
    end else begin
      if (i_capture) begin
        r_valid <= 1'b1;
        r_cx    <= i_cx;
        r_cy    <= i_cy;
        r_half  <= i_half;
        r_color <= i_color;
        r_mode  <= i_mode;
      end
      r_bnd_valid <= r_valid;
      r_l         <= w_l;
      r_r         <= w_r;
      r_t         <= w_t;
      r_b         <= w_b;
      r_bnd_mode  <= r_mode;
      r_bnd_color <= r_color;
    end
  end

  assign w_inside = r_bnd_valid && (w_x >= r_l) && (w_x <= r_r) && (w_y >= r_t) && (w_y <= r_b);

  // x > R-BORDER_W rewritten as x+BORDER_W > R so small R cannot underflow.
  assign w_border = (w_x < r_l + 11'(BORDER_W)) || (w_x + 11'(BORDER_W) > r_r) ||
                    (w_y < r_t + 11'(BORDER_W)) || (w_y + 11'(BORDER_W) > r_b);

  always_comb begin
    o_hit = 1'b0;
    unique case (r_bnd_mode)
      MODE_SOLID:   o_hit = w_inside;
      MODE_OUTLINE: o_hit = w_inside && w_border;
      MODE_BLINK:   o_hit = w_inside && i_blink_on;
      MODE_HIDDEN:  o_hit = 1'b0;
      default:      o_hit = 1'b0;
    endcase
  end

  assign o_color = r_bnd_color;

endmodule

// File: rtl/vga_box_compositor.sv
// N-box overlay stage between the VGA timing generator and the pins.
// Two-stage pipeline: S1 registers hits/bg/syncs, S2 registers the priority-muxed pixel.
module vga_box_compositor
  import vga_box_pkg::*;
#(
  parameter int unsigned N_BOXES     = 2,
  parameter int unsigned WIDTH       = 640,
  parameter int unsigned HEIGHT      = 480,
  parameter int unsigned HALF_W      = 6,
  parameter int unsigned BORDER_W    = 3,
  parameter int unsigned BLINK_SHIFT = 4,
  parameter logic        SYNC_IDLE   = 1'b1
) (
  input  logic                        clk_25mHz,
  input  logic                        reset,
  input  logic                        frame_end,
  input  logic                        active_in,
  input  logic                        hsync_in,
  input  logic                        vsync_in,
  input  logic [X_W-1:0]              x,
  input  logic [Y_W-1:0]              y,
  input  logic [COLOR_W-1:0]          bg_color,
  input  logic [N_BOXES*X_W-1:0]      box_cx,
  input  logic [N_BOXES*Y_W-1:0]      box_cy,
  input  logic [N_BOXES*HALF_W-1:0]   box_half,
  input  logic [N_BOXES*COLOR_W-1:0]  box_color,
  input  logic [N_BOXES*2-1:0]        box_mode,
  output logic                        hSync,
  output logic                        vSync,
  output logic [3:0]                  VGA_R,
  output logic [3:0]                  VGA_G,
  output logic [3:0]                  VGA_B,
  output logic [N_BOXES-1:0]          hit_mask
);

  logic                   r_frame_end_d;
  logic                   w_capture;
  logic [FRAME_CNT_W-1:0] r_frame_cnt;
  logic                   w_unused_cnt;

  logic [N_BOXES-1:0]     w_hit;
  logic [COLOR_W-1:0]     w_box_color [N_BOXES];
  logic [COLOR_W-1:0]     w_pix;

  logic [N_BOXES-1:0]     r_s1_hit;
  logic [COLOR_W-1:0]     r_s1_bg;
  logic                   r_s1_active, r_s1_hs, r_s1_vs;
  logic [COLOR_W-1:0]     r_vga;
  logic [N_BOXES-1:0]     r_hit_mask;
  logic                   r_hs, r_vs;

  assign w_capture    = frame_end & ~r_frame_end_d;
  assign w_unused_cnt = ^r_frame_cnt;

  always_ff @(posedge clk_25mHz or negedge reset) begin
    if (!reset) begin
      r_frame_end_d <= 1'b0;
      r_frame_cnt   <= '0;
    end else begin
      r_frame_end_d <= frame_end;
      if (w_capture) r_frame_cnt <= r_frame_cnt + 1'b1;
    end
  end

  for (genvar gi = 0; gi < N_BOXES; gi++) begin : g_box
    vga_box_hit #(
      .WIDTH   (WIDTH),
      .HEIGHT  (HEIGHT),
      .HALF_W  (HALF_W),
      .BORDER_W(BORDER_W)
    ) u_hit (
      .clk_25mHz (clk_25mHz),
      .reset     (reset),
      .i_capture (w_capture),
      .i_cx      (box_cx[gi*X_W +: X_W]),
      .i_cy      (box_cy[gi*Y_W +: Y_W]),
      .i_half    (box_half[gi*HALF_W +: HALF_W]),
      .i_color   (box_color[gi*COLOR_W +: COLOR_W]),
      .i_mode    (box_mode[gi*2 +: 2]),
      .i_x       (x),
      .i_y       (y),
      .i_blink_on(r_frame_cnt[BLINK_SHIFT]),
      .o_hit     (w_hit[gi]),
      .o_color   (w_box_color[gi])
    );
  end

  // Walk from the highest index down so the lowest-index hit wins.
  always_comb begin
    w_pix = r_s1_bg;
    for (int i = N_BOXES - 1; i >= 0; i--) begin
      if (r_s1_hit[i]) w_pix = w_box_color[i];
    end
  end

  always_ff @(posedge clk_25mHz or negedge reset) begin
    if (!reset) begin
      r_s1_hit    <= '0;
      r_s1_bg     <= '0;
      r_s1_active <= 1'b0;
      r_s1_hs     <= SYNC_IDLE;
      r_s1_vs     <= SYNC_IDLE;
      r_vga       <= '0;
      r_hit_mask  <= '0;
      r_hs        <= SYNC_IDLE;
      r_vs        <= SYNC_IDLE;
    end else begin
      r_s1_hit    <= w_hit;
      r_s1_bg     <= bg_color;
      r_s1_active <= active_in;
      r_s1_hs     <= hsync_in;
      r_s1_vs     <= vsync_in;
      r_vga       <= r_s1_active ? w_pix : '0;
      r_hit_mask  <= r_s1_active ? r_s1_hit : '0;
      r_hs        <= r_s1_hs;
      r_vs        <= r_s1_vs;
    end
  end

  assign VGA_R    = r_vga[11:8];
  assign VGA_G    = r_vga[7:4];
  assign VGA_B    = r_vga[3:0];
  assign hit_mask = r_hit_mask;
  assign hSync    = r_hs;
  assign vSync    = r_vs;

endmodule
